// File: rtl/ad_pkg.sv
// ad_pkg: constants shared by the register-access arbiter and the blocks
// around it (init/poll sequencer, serial register-bus engine).
//   AD_AW / AD_DW : register address / data width of the access bus
//   IDLE / OWN    : arbiter state encoding
package ad_pkg;

  localparam int AD_AW = 8;
  localparam int AD_DW = 8;

  localparam logic IDLE = 1'b0;
  localparam logic OWN  = 1'b1;

  typedef enum logic {
    ST_IDLE = IDLE,
    ST_OWN  = OWN
  } ad_state_e;

endpackage

// File: rtl/ad_arb_if.sv
// ad_arb_if: single register-access bus between the arbiter (master) and
// the serial register-bus engine (slave).
//   adaddr/adwrdata : address and write data of the current beat
//   adreq/adwr      : beat request, write(1)/read(0)
//   adlast          : last beat of a burst
//   adrddata        : read data returned by the engine
//   adack/aderr     : beat acknowledge / bus error from the engine
interface ad_arb_if;
  import ad_pkg::*;

  logic [AD_AW-1:0] adaddr;
  logic [AD_DW-1:0] adwrdata;
  logic             adreq;
  logic             adwr;
  logic             adlast;
  logic [AD_DW-1:0] adrddata;
  logic             adack;
  logic             aderr;

  modport master (
    output adaddr, adwrdata, adreq, adwr, adlast,
    input  adrddata, adack, aderr
  );

  modport slave (
    input  adaddr, adwrdata, adreq, adwr, adlast,
    output adrddata, adack, aderr
  );

endinterface

// File: rtl/ad_rr_pick.sv
// ad_rr_pick: combinational round-robin selector.
//   req_i  : request vector
//   last_i : index of the previous owner; the search starts just above it
//            and wraps, so the previous owner has the lowest priority
//   pick_o : one-hot winner (0 when no request)
//   idx_o  : index of the winner (0 when no request)
module ad_rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] pick_o,
  output logic [IW-1:0]   idx_o
);

  always_comb begin
    int   j;
    logic found;
    j      = 0;
    found  = 1'b0;
    pick_o = '0;
    idx_o  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(last_i) + k) % NREQ;
      if (!found && req_i[j]) begin
        found     = 1'b1;
        pick_o[j] = 1'b1;
        idx_o     = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ad_arb.sv
// ad_arb: shares the single register-access master port between NREQ
// requesters (init/poll sequencer, host debug port, EDID/HPD handler...).
// Grant is per transaction; a burst keeps its grant until its last beat.
//
// Ports:
//   clk, rstn          : clock, synchronous active-low reset
//   req_req/wr/last    : per-requester request, direction, last-beat flag
//   req_addr/wrdata    : per-requester address / write data, 8 bits each,
//                        requester i at [8i+7:8i]
//   req_ack/req_err    : per-requester beat acknowledge / bus error
//   req_rddata         : read data broadcast to all requesters
//   ad                 : downstream bus (ad_arb_if.master)
//   grant              : one-hot current owner, 0 when idle
//   busy               : a requester owns the bus
//
// Build option: define AD_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins); otherwise round-robin.
module ad_arb
  import ad_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_req,
  input  logic [NREQ-1:0]       req_wr,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*AD_AW-1:0] req_addr,
  input  logic [NREQ*AD_DW-1:0] req_wrdata,
  output logic [NREQ-1:0]       req_ack,
  output logic [NREQ-1:0]       req_err,
  output logic [AD_DW-1:0]      req_rddata,
  ad_arb_if.master              ad,
  output logic [NREQ-1:0]       grant,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  ad_state_e       state_q;
  logic [NREQ-1:0] grant_q;
  logic [IW-1:0]   gidx_q;
  logic [NREQ-1:0] pick;
  logic [IW-1:0]   pick_idx;
  logic            ack_ok;

  assign ack_ok = ad.adack & ~ad.aderr;

`ifdef AD_ARB_FIXED_PRIO_EN
  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_req[k]) begin
        pick     = '0;
        pick[k]  = 1'b1;
        pick_idx = IW'(k);
      end
    end
  end
`else
  logic [IW-1:0] lastgnt_q;

  ad_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req_i  (req_req),
    .last_i (lastgnt_q),
    .pick_o (pick),
    .idx_o  (pick_idx)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
`ifndef AD_ARB_FIXED_PRIO_EN
      // Previous owner = highest index, so requester 0 is searched first.
      lastgnt_q <= IW'(NREQ - 1);
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req_req) begin
            grant_q <= pick;
            gidx_q  <= pick_idx;
            state_q <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (ad.aderr || ack_ok) begin
            // Error ends the transaction regardless of adlast; a clean ack
            // on a non-last beat keeps the burst lock.
            if (ad.aderr || req_last[gidx_q]) begin
`ifndef AD_ARB_FIXED_PRIO_EN
              lastgnt_q <= gidx_q;
`endif
              grant_q   <= '0;
              state_q   <= ST_IDLE;
            end
          end else if (!req_req[gidx_q]) begin
            // Abandoned request: release without counting it as a turn.
            grant_q <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Downstream mux and response routing are combinational so the owner
  // sees its ack in the same cycle the engine gives it.
  always_comb begin
    ad.adreq    = 1'b0;
    ad.adwr     = 1'b0;
    ad.adlast   = 1'b1;
    ad.adaddr   = '0;
    ad.adwrdata = '0;
    req_ack     = '0;
    req_err     = '0;
    if (state_q == ST_OWN) begin
      ad.adreq        = req_req[gidx_q];
      ad.adwr         = req_wr[gidx_q];
      ad.adlast       = req_last[gidx_q];
      ad.adaddr       = req_addr[int'(gidx_q)*AD_AW +: AD_AW];
      ad.adwrdata     = req_wrdata[int'(gidx_q)*AD_DW +: AD_DW];
      req_ack[gidx_q] = ack_ok;
      req_err[gidx_q] = ad.aderr;
    end
  end

  assign req_rddata = ad.adrddata;
  assign grant      = grant_q;
  assign busy       = (state_q == ST_OWN);

endmodule
